// File: rtl/pc_next_if.sv
// Purpose : bundles the request, branch and PC-status signals between the control path and pc_next_unit.
// Ports   : master drives stall/branch/br_ne/zero/jump/imm/jidx and observes the PC outputs;
//           slave is the PC unit, which consumes the requests and drives pc_out, adders, redirect, pend_valid, upd_count.
interface pc_next_if #(
   parameter int WIDTH  = 32,
   parameter int IMM_W  = 16,
   parameter int JIDX_W = 26,
   parameter int CNT_W  = 32
);
   logic              stall;
   logic              branch;
   logic              br_ne;
   logic              zero;
   logic              jump;
   logic [IMM_W-1:0]  imm;
   logic [JIDX_W-1:0] jidx;
   logic [WIDTH-1:0]  pc_out;
   logic [WIDTH-1:0]  adder1_out;
   logic [WIDTH-1:0]  adder2_out;
   logic              redirect;
   logic              pend_valid;
   logic [CNT_W-1:0]  upd_count;

   modport master (
      output stall, branch, br_ne, zero, jump, imm, jidx,
      input  pc_out, adder1_out, adder2_out, redirect, pend_valid, upd_count
   );

   modport slave (
      input  stall, branch, br_ne, zero, jump, imm, jidx,
      output pc_out, adder1_out, adder2_out, redirect, pend_valid, upd_count
   );
endinterface

// File: rtl/pc_next_unit.sv
// Purpose : PC register with sequential/branch/jump next-PC select and a one-deep redirect buffer for stalls.
// Latency : adders are combinational; the selected next PC appears on pc_out one cycle after the selecting edge.
// Stall   : stall holds the PC; the first redirect seen under stall is buffered and applied on release, later ones dropped.
// Ports   : clk, reset (synchronous, active-high) plus the slave side of pc_next_if.
module pc_next_unit #(
   parameter int               WIDTH      = 32,
   parameter int               IMM_W      = 16,
   parameter int               JIDX_W     = 26,
   parameter int               SHIFT      = 2,
   parameter int               INC        = 4,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter int               CNT_W      = 32
) (
   input  logic       clk,
   input  logic       reset,
   pc_next_if.slave   bus
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic             pend_valid_q, pend_valid_d;
   logic             redirect_q, redirect_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] adder1;
   logic [WIDTH-1:0] adder2;
   logic [WIDTH-1:0] imm_sext;
   logic [WIDTH-1:0] jtgt;
   logic             take_br;
   logic             req;
   logic [WIDTH-1:0] req_addr;

   // Arithmetic is modulo 2^WIDTH; carries out of the top bit are simply lost.
   assign adder1   = pc_q + WIDTH'(INC);
   assign imm_sext = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
   assign adder2   = adder1 + (imm_sext << SHIFT);

   // Jump target keeps the upper region bits of the sequential PC.
   assign jtgt     = {adder1[WIDTH-1:JIDX_W+SHIFT], bus.jidx, {SHIFT{1'b0}}};

   assign take_br  = bus.branch & (bus.zero ^ bus.br_ne);
   assign req      = bus.jump | take_br;
   assign req_addr = bus.jump ? jtgt : adder2;

   always_comb begin
      pc_d         = pc_q;
      pend_addr_d  = pend_addr_q;
      pend_valid_d = pend_valid_q;
      redirect_d   = 1'b0;
      cnt_d        = cnt_q;
      if (bus.stall) begin
         // Only the first redirect under a stall is kept; the PC itself holds.
         if (!pend_valid_q && req) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = req_addr;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         if (pend_valid_q) begin
            // Buffered redirect is older than anything presented now, so it wins.
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
            redirect_d   = 1'b1;
         end else if (req) begin
            pc_d       = req_addr;
            redirect_d = 1'b1;
         end else begin
            pc_d = adder1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_ADDR;
         pend_addr_q  <= '0;
         pend_valid_q <= 1'b0;
         redirect_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         pc_q         <= pc_d;
         pend_addr_q  <= pend_addr_d;
         pend_valid_q <= pend_valid_d;
         redirect_q   <= redirect_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.pc_out     = pc_q;
   assign bus.adder1_out = adder1;
   assign bus.adder2_out = adder2;
   assign bus.redirect   = redirect_q;
   assign bus.pend_valid = pend_valid_q;
   assign bus.upd_count  = cnt_q;

endmodule
